pinwheel_hart_sched: RTL and testbench
======================================

Name: pinwheel_hart_sched

Overview:
- Hart scheduler for the pinwheel core. Owns the per-hart resume PCs and run state.
- Each cycle it picks one runnable hart round-robin and presents that hart's HPC to the core's stage A. HPC bits [26:24] carry the hart index; HPC 0 is a bubble.
- It takes back the next HPC the core computes for the in-flight hart.
- It exposes a valid/ready command port (debug / supervisor) to start, stop and re-point harts.

Parameters:
- HARTS, 8, number of hardware threads (power of two, max 8).
- RESET_PC, 32'h00400000, resume PC loaded into hart 0 at reset.

Ports:
- clock  in  1  global clock.
- reset_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid.
- cmd_op  in  2  0=START, 1=STOP, 2=SETPC, 3=reserved (accepted, no effect).
- cmd_hart  in  3  target hart index.
- cmd_pc  in  32  PC for SETPC.
- ret_valid  in  1  core returns a next-HPC this cycle.
- ret_hpc  in  32  returned HPC; hart = ret_hpc[26:24].
- issue_valid  out  1  issue_hpc holds a real hart.
- issue_hpc  out  32  HPC driven into stage A; 0 when bubble.
- active_mask  out  HARTS  bit h set iff hart h is READY or INFLIGHT.
- issue_count  out  32  number of non-bubble issues since reset, wraps at 2^32.

Behaviour:
- Per-hart state: IDLE, READY or INFLIGHT, plus a stop_pending flag and a 32-bit pc_table entry.
- All outputs except cmd_ready are registered. cmd_ready is combinational from the target hart's state.
- Reset (reset_n=0 at posedge):
  - All harts IDLE and stop_pending cleared.
  - Then hart 0 set READY with pc_table[0]=RESET_PC.
  - rr_ptr=HARTS-1, issue_valid=0, issue_hpc=0, issue_count=0.
  - Reset mid-operation discards in-flight returns and pending commands. A ret_valid seen while reset_n=0 is ignored.
- Issue, every cycle:
  - Search h = rr_ptr+1 … rr_ptr+HARTS (mod HARTS) for the first READY hart.
  - If found: issue_valid<=1, issue_hpc<={pc_table[h][31:27], h[2:0], pc_table[h][23:0]}, state[h]<=INFLIGHT, rr_ptr<=h, issue_count++.
  - If none: issue_valid<=0, issue_hpc<=0, rr_ptr unchanged.
- Return (ret_valid=1), with h=ret_hpc[26:24]:
  - If state[h] != INFLIGHT: ignored.
  - If ret_hpc[23:0]==0: the hart terminated itself. state<=IDLE, pc_table unchanged.
  - Else if stop_pending[h]: pc_table[h]<=ret_hpc, state<=IDLE, stop_pending<=0.
  - Else: pc_table[h]<=ret_hpc, state<=READY.
  - A returned hart is eligible for issue no earlier than the following cycle, so the minimum re-issue gap is 2 cycles.
- Commands:
  - cmd_ready=0 iff state[cmd_hart]==INFLIGHT and cmd_op is START or SETPC. Otherwise cmd_ready=1.
  - cmd_hart >= HARTS: accepted, no effect.
  - START: if IDLE -> READY, otherwise no effect.
  - STOP: READY -> IDLE; INFLIGHT -> stop_pending<=1 (accepted immediately); IDLE -> no effect.
  - SETPC (IDLE or READY): pc_table<={cmd_pc[31:27], hart, cmd_pc[23:0]}. State unchanged.
- Same-cycle events:
  - A command and the issue selection both use start-of-cycle state. A STOP on a hart that is being selected this cycle sees READY, so the hart is issued; the STOP is then treated as INFLIGHT and sets stop_pending.
  - A return and a command to the same hart in the same cycle: the command sees INFLIGHT, so START/SETPC stall; STOP sets stop_pending and the return consumes it that same cycle (hart ends IDLE).
  - A return for hart h and the issue selection in the same cycle: h is not considered for issue that cycle.
- Latency: START accepted at edge t -> READY after t -> earliest issue_valid at edge t+1.

Test Plan:
- Reset release: hold reset_n=0 for 2 cycles, release -> issue_valid=1, issue_hpc=32'h00400000 at the first edge; active_mask=8'h01.
- Round-robin: SETPC hart2=0x0040_0100 and hart5=0x0040_0200, START 2 and 5, with ret returning PC+4 each time -> issue order 0,2,5,0,2,5; issue_hpc for hart5 = 0x0540_0200.
- STOP in flight: STOP hart 2 while INFLIGHT -> cmd_ready=1; the return 0x0240_0104 lands in pc_table; hart2 is never reissued; active_mask bit2 clears.
- SETPC stall: SETPC to an INFLIGHT hart -> cmd_ready=0 until its return cycle, then accepted and the new PC is issued next.
- Self-termination: ret_hpc=0x0300_0000 for hart 3 -> hart3 IDLE; issue_valid=0 and issue_hpc=0 when no other hart is READY; issue_count stops incrementing.
- Mid-run reset: with 3 harts active, pulse reset_n low 1 cycle -> only hart 0 runs at 0x00400000; issue_count=1 after the first issue.

Source files
------------

// File: rtl/pinwheel_hart_sched.sv
// Hart scheduler for the pinwheel core.
// Keeps per-hart resume PCs and run state, picks one READY hart per cycle
// round-robin, drives its HPC into stage A, and takes back the next HPC the core
// computes for an in-flight hart. A valid/ready command port starts, stops and
// re-points harts.
//   clock, reset_n   : clock and synchronous active-low reset
//   cmd_valid/ready  : command handshake (cmd_ready is combinational)
//   cmd_op/hart/pc   : 0=START 1=STOP 2=SETPC 3=reserved, target hart, SETPC value
//   ret_valid/hpc    : next HPC returned by the core, hart in ret_hpc[26:24]
//   issue_valid/hpc  : registered issue slot, issue_hpc=0 on a bubble
//   active_mask      : registered, bit h set while hart h is READY or INFLIGHT
//   issue_count      : registered count of non-bubble issues, wraps
`timescale 1ns/1ps
module pinwheel_hart_sched #(
  parameter int unsigned HARTS    = 8,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_hart,
  input  logic [31:0]      cmd_pc,
  input  logic             ret_valid,
  input  logic [31:0]      ret_hpc,
  output logic             issue_valid,
  output logic [31:0]      issue_hpc,
  output logic [HARTS-1:0] active_mask,
  output logic [31:0]      issue_count
);

  localparam int unsigned IW = (HARTS > 1) ? $clog2(HARTS) : 1;

  typedef enum logic [1:0] {HS_IDLE, HS_READY, HS_INFLIGHT} hart_state_e;
  typedef enum logic [1:0] {OP_START, OP_STOP, OP_SETPC, OP_RSVD} cmd_op_e;

  hart_state_e      state_q [HARTS];
  hart_state_e      state_d [HARTS];
  logic [31:0]      pc_q    [HARTS];
  logic [31:0]      pc_d    [HARTS];
  logic [HARTS-1:0] stop_q, stop_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [HARTS-1:0] active_d;

  logic [IW-1:0]    cmd_idx, ret_idx, sel_idx, cand;
  logic             cmd_in_range, ret_in_range, ret_hit, sel_found;
  logic             cmd_fire, ret_same;
  cmd_op_e          op;

  // The hart field of a SETPC value is replaced by the target index
  logic unused_cmd_pc_hart;
  assign unused_cmd_pc_hart = ^cmd_pc[26:24];

  // Decode command and return targets; stall START/SETPC on an in-flight hart
  always_comb begin
    op           = cmd_op_e'(cmd_op);
    cmd_idx      = cmd_hart[IW-1:0];
    ret_idx      = ret_hpc[24 +: IW];
    cmd_in_range = 32'(cmd_hart) < HARTS;
    ret_in_range = 32'(ret_hpc[26:24]) < HARTS;
    ret_hit      = ret_valid && ret_in_range && (state_q[ret_idx] == HS_INFLIGHT);
    ret_same     = ret_hit && (ret_idx == cmd_idx);
    cmd_ready    = 1'b1;
    if (cmd_in_range && (state_q[cmd_idx] == HS_INFLIGHT) &&
        ((op == OP_START) || (op == OP_SETPC)))
      cmd_ready = 1'b0;
    cmd_fire     = cmd_valid && cmd_ready && cmd_in_range;
  end

  // Round-robin search starting after the last issued hart
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= int'(HARTS); i++) begin
      cand = rr_q + IW'(i);
      if (!sel_found && (state_q[cand] == HS_READY)) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Next state: issue, return and command all judged on start-of-cycle state
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stop_d  = stop_q;
    rr_d    = rr_q;

    if (sel_found) begin
      state_d[sel_idx] = HS_INFLIGHT;
      rr_d             = sel_idx;
    end

    if (ret_hit) begin
      stop_d[ret_idx] = 1'b0;
      if (ret_hpc[23:0] == 24'd0) begin
        state_d[ret_idx] = HS_IDLE;
      end else begin
        pc_d[ret_idx] = ret_hpc;
        // A STOP landing in the return cycle is consumed by this return
        if (stop_q[ret_idx] || (cmd_fire && (op == OP_STOP) && ret_same))
          state_d[ret_idx] = HS_IDLE;
        else
          state_d[ret_idx] = HS_READY;
      end
    end

    if (cmd_fire) begin
      case (op)
        OP_START: if (state_q[cmd_idx] == HS_IDLE) state_d[cmd_idx] = HS_READY;
        OP_STOP: begin
          if (state_q[cmd_idx] == HS_READY) begin
            // Being issued this cycle: behaves as a STOP on an in-flight hart
            if (sel_found && (sel_idx == cmd_idx)) stop_d[cmd_idx] = 1'b1;
            else                                   state_d[cmd_idx] = HS_IDLE;
          end else if ((state_q[cmd_idx] == HS_INFLIGHT) && !ret_same) begin
            stop_d[cmd_idx] = 1'b1;
          end
        end
        OP_SETPC: pc_d[cmd_idx] = {cmd_pc[31:27], cmd_hart, cmd_pc[23:0]};
        default: ;
      endcase
    end

    active_d = '0;
    for (int h = 0; h < int'(HARTS); h++)
      active_d[h] = (state_d[h] != HS_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int h = 0; h < int'(HARTS); h++) begin
        state_q[h] <= (h == 0) ? HS_READY : HS_IDLE;
        pc_q[h]    <= (h == 0) ? RESET_PC : 32'd0;
      end
      stop_q      <= '0;
      rr_q        <= IW'(HARTS - 1);
      issue_valid <= 1'b0;
      issue_hpc   <= 32'd0;
      issue_count <= 32'd0;
      active_mask <= HARTS'(1);
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      stop_q      <= stop_d;
      rr_q        <= rr_d;
      issue_valid <= sel_found;
      issue_hpc   <= sel_found ? {pc_q[sel_idx][31:27], 3'(sel_idx), pc_q[sel_idx][23:0]}
                               : 32'd0;
      if (sel_found) issue_count <= issue_count + 32'd1;
      active_mask <= active_d;
    end
  end

endmodule

// File: tb/tb_pinwheel_hart_sched.sv
// Directed bench for pinwheel_hart_sched: round-robin order, stop in flight,
// SETPC stall, self-termination, mid-run reset and STOP racing issue.
`timescale 1ns/1ps
module tb_pinwheel_hart_sched;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_SETPC = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, ret_valid, issue_valid;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_hart;
  logic [31:0] cmd_pc, ret_hpc, issue_hpc, issue_count;
  logic [7:0]  active_mask;

  int n_cmp = 0;
  int n_err = 0;

  pinwheel_hart_sched #(.HARTS(8), .RESET_PC(32'h0040_0000)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_hart    (cmd_hart),
    .cmd_pc      (cmd_pc),
    .ret_valid   (ret_valid),
    .ret_hpc     (ret_hpc),
    .issue_valid (issue_valid),
    .issue_hpc   (issue_hpc),
    .active_mask (active_mask),
    .issue_count (issue_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_iss(input string tag, input logic v, input logic [31:0] hpc,
                         input logic [31:0] cnt);
    chk({tag, ".valid"}, 32'(issue_valid), 32'(v));
    chk({tag, ".hpc"},   issue_hpc,        hpc);
    chk({tag, ".count"}, issue_count,      cnt);
  endtask

  task automatic chk_mask(input string tag, input logic [7:0] m);
    chk({tag, ".mask"}, 32'(active_mask), 32'(m));
  endtask

  task automatic chk_rdy(input string tag, input logic r);
    #1;
    chk({tag, ".ready"}, 32'(cmd_ready), 32'(r));
  endtask

  task automatic set_in(input logic cv, input logic [1:0] op, input logic [2:0] h,
                        input logic [31:0] pc, input logic rv, input logic [31:0] rh);
    cmd_valid = cv;
    cmd_op    = op;
    cmd_hart  = h;
    cmd_pc    = pc;
    ret_valid = rv;
    ret_hpc   = rh;
  endtask

  task automatic quiet();
    set_in(1'b0, OP_RSVD, 3'd0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    quiet();
    tick();
    tick();
    chk_iss("reset", 1'b0, 32'h0, 32'd0);
    chk_mask("reset", 8'h01);

    reset_n = 1'b1;
    tick();
    chk_iss("e1", 1'b1, 32'h0040_0000, 32'd1);
    chk_mask("e1", 8'h01);

    // Point harts 2 and 5, start them while hart 0 returns
    set_in(1'b1, OP_SETPC, 3'd2, 32'h0040_0100, 1'b0, 32'h0);
    chk_rdy("setpc2", 1'b1);
    tick();
    chk_iss("e2", 1'b0, 32'h0, 32'd1);
    set_in(1'b1, OP_SETPC, 3'd5, 32'h0040_0200, 1'b0, 32'h0);
    tick();
    set_in(1'b1, OP_START, 3'd2, 32'h0, 1'b1, 32'h0040_0004);
    tick();
    chk_iss("e4", 1'b0, 32'h0, 32'd1);
    set_in(1'b1, OP_START, 3'd5, 32'h0, 1'b0, 32'h0);
    tick();
    chk_iss("rr_h2", 1'b1, 32'h0240_0100, 32'd2);

    // Round-robin with PC+4 returns
    set_in(1'b0, OP_RSVD, 3'd0, 32'h0, 1'b1, 32'h0240_0104);
    tick();
    chk_iss("rr_h5", 1'b1, 32'h0540_0200, 32'd3);
    set_in(1'b0, OP_RSVD, 3'd0, 32'h0, 1'b1, 32'h0540_0204);
    tick();
    chk_iss("rr_h0", 1'b1, 32'h0040_0004, 32'd4);
    set_in(1'b0, OP_RSVD, 3'd0, 32'h0, 1'b1, 32'h0040_0008);
    tick();
    chk_iss("rr_h2b", 1'b1, 32'h0240_0104, 32'd5);
    set_in(1'b0, OP_RSVD, 3'd0, 32'h0, 1'b1, 32'h0240_0108);
    tick();
    chk_iss("rr_h5b", 1'b1, 32'h0540_0204, 32'd6);
    chk_mask("rr_h5b", 8'h25);
    set_in(1'b0, OP_RSVD, 3'd0, 32'h0, 1'b1, 32'h0540_0208);
    tick();
    chk_iss("e10", 1'b1, 32'h0040_0008, 32'd7);
    set_in(1'b0, OP_RSVD, 3'd0, 32'h0, 1'b1, 32'h0040_000C);
    tick();
    chk_iss("e11", 1'b1, 32'h0240_0108, 32'd8);

    // STOP hart 2 while in flight; its return parks it IDLE
    set_in(1'b1, OP_STOP, 3'd2, 32'h0, 1'b0, 32'h0);
    chk_rdy("stop_inflight", 1'b1);
    tick();
    chk_iss("e12", 1'b1, 32'h0540_0208, 32'd9);
    set_in(1'b0, OP_RSVD, 3'd0, 32'h0, 1'b1, 32'h0240_010C);
    tick();
    chk_iss("e13", 1'b1, 32'h0040_000C, 32'd10);
    chk_mask("stop_done", 8'h21);

    // SETPC stall: hart 5 in flight, hart 0 wins the slot on the return edge
    set_in(1'b1, OP_SETPC, 3'd3, 32'h0040_0300, 1'b1, 32'h0540_020C);
    tick();
    chk_iss("e14", 1'b0, 32'h0, 32'd10);
    set_in(1'b1, OP_START, 3'd3, 32'h0, 1'b1, 32'h0040_0010);
    tick();
    chk_iss("e15", 1'b1, 32'h0540_020C, 32'd11);
    set_in(1'b1, OP_SETPC, 3'd5, 32'h0040_7000, 1'b1, 32'h0540_0210);
    chk_rdy("setpc_stall", 1'b0);
    tick();
    chk_iss("e16", 1'b1, 32'h0040_0010, 32'd12);
    set_in(1'b1, OP_SETPC, 3'd5, 32'h0040_7000, 1'b0, 32'h0);
    chk_rdy("setpc_accept", 1'b1);
    tick();
    chk_iss("e17", 1'b1, 32'h0340_0300, 32'd13);
    quiet();
    tick();
    chk_iss("setpc_new", 1'b1, 32'h0540_7000, 32'd14);

    // Hart 3 terminates itself; nothing READY
    set_in(1'b0, OP_RSVD, 3'd0, 32'h0, 1'b1, 32'h0300_0000);
    tick();
    chk_iss("selfterm", 1'b0, 32'h0, 32'd14);
    chk_mask("selfterm", 8'h21);

    // STOP and return to hart 0 in the same cycle: ends IDLE
    set_in(1'b1, OP_STOP, 3'd0, 32'h0, 1'b1, 32'h0040_0014);
    chk_rdy("stop_ret", 1'b1);
    tick();
    chk_iss("e20", 1'b0, 32'h0, 32'd14);
    chk_mask("stop_ret", 8'h20);
    set_in(1'b0, OP_RSVD, 3'd0, 32'h0, 1'b1, 32'h0540_7004);
    tick();
    chk_mask("e21", 8'h20);
    set_in(1'b1, OP_START, 3'd0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_iss("e22", 1'b1, 32'h0540_7004, 32'd15);
    set_in(1'b1, OP_START, 3'd3, 32'h0, 1'b0, 32'h0);
    tick();
    chk_iss("e23", 1'b1, 32'h0040_0014, 32'd16);
    chk_mask("three_active", 8'h29);

    // Mid-run reset, with a stale return around it
    reset_n = 1'b0;
    set_in(1'b0, OP_RSVD, 3'd0, 32'h0, 1'b1, 32'h0540_7008);
    tick();
    chk_iss("midreset", 1'b0, 32'h0, 32'd0);
    chk_mask("midreset", 8'h01);
    reset_n = 1'b1;
    tick();
    chk_iss("after_reset", 1'b1, 32'h0040_0000, 32'd1);
    chk_mask("after_reset", 8'h01);

    // cmd_ready per op against an in-flight hart
    set_in(1'b0, OP_START, 3'd0, 32'h0, 1'b0, 32'h0);
    chk_rdy("rdy_start", 1'b0);
    cmd_op = OP_STOP;
    chk_rdy("rdy_stop", 1'b1);
    cmd_op = OP_RSVD;
    chk_rdy("rdy_rsvd", 1'b1);
    cmd_op = OP_START; cmd_hart = 3'd1;
    chk_rdy("rdy_idle", 1'b1);
    set_in(1'b1, OP_RSVD, 3'd0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_iss("rsvd", 1'b0, 32'h0, 32'd1);
    chk_mask("rsvd", 8'h01);

    // STOP on a hart being issued in the same cycle
    set_in(1'b0, OP_RSVD, 3'd0, 32'h0, 1'b1, 32'h0040_0004);
    tick();
    set_in(1'b1, OP_STOP, 3'd0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_iss("stop_race", 1'b1, 32'h0040_0004, 32'd2);
    set_in(1'b0, OP_RSVD, 3'd0, 32'h0, 1'b1, 32'h0040_0008);
    tick();
    chk_iss("stop_race_ret", 1'b0, 32'h0, 32'd2);
    chk_mask("stop_race_ret", 8'h00);

    // Restart latency: START at edge t, issue at t+1 with the saved PC
    set_in(1'b1, OP_START, 3'd0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_iss("restart_t", 1'b0, 32'h0, 32'd2);
    chk_mask("restart_t", 8'h01);
    quiet();
    tick();
    chk_iss("restart_t1", 1'b1, 32'h0040_0008, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
